hiscore_saver: RTL

- Read-side companion to the hiscore loader: snapshots the game-RAM regions described by the hiscore config table into a local buffer.
- Serves that buffer to the HPS over the ioctl upload stream (ioctl_index 4), so scores can be written to SD.
- Sits between the core's game-RAM second port and hps_io.
- Shares the config download (ioctl_index 3) format with the loader: 8 bytes per entry, with bytes 1..3 = 24-bit address and byte 4 = length.

---
 rtl/hiscore_saver_if.sv | 41 ++++
 rtl/hiscore_saver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_saver_if.sv
// Bus bundle between hiscore_saver and its environment: the hps_io ioctl
// download/upload stream, the game-RAM read port and the save control/status.
//   ioctl_download/upload/wr/addr/dout/index : HPS side, into the saver
//   ioctl_din                                : upload data back to HPS
//   save_req                                 : one-cycle snapshot request
//   ram_address/ram_read -> ram_din          : game-RAM read port
//   busy/done/used_bytes/overflow            : snapshot status
// master = environment (hps_io + core), slave = hiscore_saver.
interface hiscore_saver_if #(
  parameter int unsigned BUF_BYTES = 32
);
  localparam int unsigned UsedW = $clog2(BUF_BYTES) + 1;

  logic             ioctl_download;
  logic             ioctl_upload;
  logic             ioctl_wr;
  logic [24:0]      ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic [7:0]       ioctl_index;
  logic [7:0]       ioctl_din;
  logic             save_req;
  logic [9:0]       ram_address;
  logic             ram_read;
  logic [7:0]       ram_din;
  logic             busy;
  logic             done;
  logic [UsedW-1:0] used_bytes;
  logic             overflow;

  modport master (
    output ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output save_req, ram_din,
    input  ioctl_din, ram_address, ram_read, busy, done, used_bytes, overflow
  );

  modport slave (
    input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  save_req, ram_din,
    output ioctl_din, ram_address, ram_read, busy, done, used_bytes, overflow
  );
endinterface

// File: rtl/hiscore_saver.sv
// hiscore_saver: snapshots the game-RAM regions listed in the hiscore config
// table (ioctl index 3, 8 bytes per entry) into a local buffer and serves it
// back to the HPS on the upload stream (ioctl index 4).
// Ports:
//   clk      core clock
//   reset_n  synchronous active-low reset
//   bus      hiscore_saver_if.slave (ioctl stream, game-RAM port, status)
// Optional feature: define HISCORE_CHECKSUM_EN to append an 8-bit sum of the
// captured bytes at upload address used_bytes.
module hiscore_saver #(
  parameter int unsigned MAX_ENTRIES = 16,
  parameter int unsigned BUF_BYTES   = 32,
  parameter int unsigned RAM_LATENCY = 1
) (
  input logic            clk,
  input logic            reset_n,
  hiscore_saver_if.slave bus
);
  localparam int unsigned EntW = $clog2(MAX_ENTRIES);
  localparam int unsigned PtrW = $clog2(BUF_BYTES);
  localparam int unsigned PtrW1 = PtrW + 1;
  localparam logic [PtrW:0] BufFull = PtrW1'(BUF_BYTES);
  localparam logic [1:0] WaitLast = 2'(RAM_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle, StLookup, StCheck, StWait, StStore, StNext, StFinish
  } state_e;

  // Only the low 10 address bits are kept: the truncated 10-bit sum cannot
  // depend on the upper bits of the 24-bit base.
  logic [9:0]      addr_tbl [MAX_ENTRIES];
  logic [7:0]      len_tbl  [MAX_ENTRIES];
  logic [7:0]      snap_mem [BUF_BYTES];
  logic [1:0]      addr_mid_q;
  logic [EntW-1:0] total_entries_q;
  logic            config_valid_q, download_q, upload_q;

  state_e          state_q, state_d;
  logic [EntW-1:0] entry_q, entry_d;
  logic [PtrW:0]   ptr_q, ptr_d, used_q, used_d;
  logic [8:0]      byte_ctr_q, byte_ctr_d;
  logic [1:0]      wait_q, wait_d;
  logic [9:0]      cur_addr_q, cur_addr_d, ram_address_q, ram_address_d;
  logic [7:0]      cur_len_q, cur_len_d, din_q, din_d;
  logic            ram_read_q, ram_read_d, busy_q, busy_d, done_q, done_d;
  logic            overflow_q, overflow_d, store_en;
`ifdef HISCORE_CHECKSUM_EN
  logic [7:0]      acc_q, acc_d, chk_q, chk_d;
`endif

  logic idx3, cfg_wr, dl_rise, dl_fall, ul_rise;
  assign idx3    = (bus.ioctl_index == 8'd3);
  assign cfg_wr  = bus.ioctl_download & bus.ioctl_wr & idx3;
  assign dl_rise = bus.ioctl_download & ~download_q & idx3;
  assign dl_fall = ~bus.ioctl_download & download_q & idx3;
  assign ul_rise = bus.ioctl_upload & ~upload_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      total_entries_q <= '0;
      config_valid_q  <= 1'b0;
      download_q      <= 1'b0;
      upload_q        <= 1'b0;
    end else begin
      download_q <= bus.ioctl_download;
      upload_q   <= bus.ioctl_upload;
      if (cfg_wr) total_entries_q <= bus.ioctl_addr[EntW+2:3];
      if (dl_rise) config_valid_q <= 1'b0;
      else if (dl_fall) config_valid_q <= 1'b1;
    end
  end

  // Table and buffer storage carry no reset.
  always_ff @(posedge clk) begin
    if (reset_n && cfg_wr) begin
      case (bus.ioctl_addr[2:0])
        3'd2: addr_mid_q <= bus.ioctl_dout[1:0];
        3'd3: addr_tbl[bus.ioctl_addr[EntW+2:3]] <= {addr_mid_q, bus.ioctl_dout};
        3'd4: len_tbl[bus.ioctl_addr[EntW+2:3]] <= bus.ioctl_dout;
        default: ;
      endcase
    end
    if (reset_n && store_en) snap_mem[ptr_q[PtrW-1:0]] <= bus.ram_din;
  end

  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    ptr_d         = ptr_q;
    used_d        = used_q;
    byte_ctr_d    = byte_ctr_q;
    wait_d        = wait_q;
    cur_addr_d    = cur_addr_q;
    cur_len_d     = cur_len_q;
    ram_address_d = ram_address_q;
    ram_read_d    = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    overflow_d    = overflow_q;
    store_en      = 1'b0;
`ifdef HISCORE_CHECKSUM_EN
    acc_d         = acc_q;
    chk_d         = chk_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.save_req && config_valid_q && !bus.ioctl_upload && !bus.ioctl_download) begin
          entry_d    = '0;
          ptr_d      = '0;
          overflow_d = 1'b0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
`ifdef HISCORE_CHECKSUM_EN
          acc_d      = 8'h00;
`endif
          state_d    = StLookup;
        end
      end
      StLookup: begin
        cur_addr_d = addr_tbl[entry_q];
        cur_len_d  = len_tbl[entry_q];
        byte_ctr_d = '0;
        state_d    = StCheck;
      end
      StCheck: begin
        if (cur_len_q == 8'd0) begin
          state_d = StNext;
        end else if (ptr_q == BufFull) begin
          overflow_d = 1'b1;
          state_d    = StFinish;
        end else begin
          ram_address_d = cur_addr_q + 10'(byte_ctr_q);
          ram_read_d    = 1'b1;
          wait_d        = '0;
          state_d       = StWait;
        end
      end
      StWait: begin
        if (wait_q == WaitLast) state_d = StStore;
        else wait_d = wait_q + 2'd1;
      end
      StStore: begin
        store_en   = 1'b1;
        ptr_d      = ptr_q + 1'b1;
        byte_ctr_d = byte_ctr_q + 9'd1;
`ifdef HISCORE_CHECKSUM_EN
        acc_d      = acc_q + bus.ram_din;
`endif
        if (byte_ctr_q + 9'd1 == {1'b0, cur_len_q}) state_d = StNext;
        else state_d = StCheck;
      end
      StNext: begin
        if (entry_q == total_entries_q) begin
          state_d = StFinish;
        end else begin
          entry_d = entry_q + 1'b1;
          state_d = StLookup;
        end
      end
      StFinish: begin
        used_d  = ptr_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef HISCORE_CHECKSUM_EN
        chk_d   = acc_q;
        // A full buffer leaves no slot for the checksum byte.
        if (ptr_q == BufFull) overflow_d = 1'b1;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // New config or an upload starting mid-snapshot abandons the capture.
    if (dl_rise || (ul_rise && busy_q)) begin
      state_d    = StIdle;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      ram_read_d = 1'b0;
      store_en   = 1'b0;
    end
  end

  always_comb begin
    din_d = 8'h00;
    if (bus.ioctl_upload && bus.ioctl_index == 8'd4) begin
      if (bus.ioctl_addr < 25'(used_q)) din_d = snap_mem[bus.ioctl_addr[PtrW-1:0]];
`ifdef HISCORE_CHECKSUM_EN
      else if (bus.ioctl_addr == 25'(used_q)) din_d = chk_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      entry_q       <= '0;
      ptr_q         <= '0;
      used_q        <= '0;
      byte_ctr_q    <= '0;
      wait_q        <= '0;
      cur_addr_q    <= '0;
      cur_len_q     <= '0;
      ram_address_q <= '0;
      ram_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      din_q         <= 8'h00;
`ifdef HISCORE_CHECKSUM_EN
      acc_q         <= 8'h00;
      chk_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      ptr_q         <= ptr_d;
      used_q        <= used_d;
      byte_ctr_q    <= byte_ctr_d;
      wait_q        <= wait_d;
      cur_addr_q    <= cur_addr_d;
      cur_len_q     <= cur_len_d;
      ram_address_q <= ram_address_d;
      ram_read_q    <= ram_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      din_q         <= din_d;
`ifdef HISCORE_CHECKSUM_EN
      acc_q         <= acc_d;
      chk_q         <= chk_d;
`endif
    end
  end

  assign bus.ram_address = ram_address_q;
  assign bus.ram_read    = ram_read_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.used_bytes  = used_q;
  assign bus.overflow    = overflow_q;
  assign bus.ioctl_din   = din_q;
endmodule
